// File: rtl/branch_target_predictor.sv
// Purpose : direct-mapped branch target buffer with per-entry saturating direction
//           counters, resolve-stage mispredict/redirect generation and statistics.
// Latency : lookup is combinational (0 cycles); training is visible the cycle after resolve.
// Backpressure: none issued; pipe_stall masks the resolve-stage inputs for that cycle.
//
// Ports:
//   clk, reset                      single clock, synchronous active-high reset
//   f_pc -> f_hit/f_taken/f_target  fetch-stage lookup
//   r_branch, r_equal, r_pc,        resolve-stage branch description and the
//   r_target, r_pred_hit,           prediction that travelled down with it
//   r_pred_taken, pipe_stall
//   flush_btb                       invalidate every entry at the next edge
//   mispredict, redirect_pc         fetch redirect (combinational)
//   branch_cnt, mispred_cnt         wrapping statistics counters
module branch_target_predictor #(
    parameter int ENTRIES = 16,
    parameter int ADDR_W  = 32,
    parameter int CTR_W   = 2,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] f_pc,
    output logic              f_hit,
    output logic              f_taken,
    output logic [ADDR_W-1:0] f_target,
    input  logic [1:0]        r_branch,
    input  logic              r_equal,
    input  logic [ADDR_W-1:0] r_pc,
    input  logic [ADDR_W-1:0] r_target,
    input  logic              r_pred_hit,
    input  logic              r_pred_taken,
    input  logic              pipe_stall,
    input  logic              flush_btb,
    output logic              mispredict,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic [CNT_W-1:0]  branch_cnt,
    output logic [CNT_W-1:0]  mispred_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] WEAK_T  = CTR_W'(1 << (CTR_W - 1));
    localparam logic [CTR_W-1:0] WEAK_NT = CTR_W'((1 << (CTR_W - 1)) - 1);

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tag_mem [ENTRIES];
    logic [ADDR_W-1:0]  tgt_mem [ENTRIES];
    logic [CTR_W-1:0]   ctr_mem [ENTRIES];

    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic [IDX_W-1:0] r_idx;
    logic [TAG_W-1:0] r_tag;

    logic resolve;
    logic actual;

    assign f_idx = f_pc[IDX_W+1:2];
    assign f_tag = f_pc[ADDR_W-1:IDX_W+2];
    assign r_idx = r_pc[IDX_W+1:2];
    assign r_tag = r_pc[ADDR_W-1:IDX_W+2];

    // Lookup reads the table as it stands before this edge: no write bypass.
    assign f_hit    = valid[f_idx] && (tag_mem[f_idx] == f_tag);
    assign f_taken  = f_hit && ctr_mem[f_idx][CTR_W-1];
    assign f_target = f_hit ? tgt_mem[f_idx] : '0;

    // bne is taken when the operands differ, beq when they match.
    assign resolve     = r_branch[0] && !pipe_stall;
    assign actual      = r_branch[1] ? !r_equal : r_equal;
    assign mispredict  = resolve && (r_pred_taken != actual);
    assign redirect_pc = actual ? r_target : (r_pc + ADDR_W'(4));

    always_ff @(posedge clk) begin
        if (reset) begin
            valid       <= '0;
            branch_cnt  <= '0;
            mispred_cnt <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_mem[i] <= WEAK_NT;
            end
        end else begin
            if (resolve) begin
                branch_cnt <= branch_cnt + CNT_W'(1);
            end
            if (mispredict) begin
                mispred_cnt <= mispred_cnt + CNT_W'(1);
            end

            // A flush wins over any same-cycle table write; ctr/target survive it.
            if (flush_btb) begin
                valid <= '0;
            end else if (resolve) begin
                if (!r_pred_hit) begin
                    // Only taken branches earn an entry; fall-throughs need no target.
                    if (actual) begin
                        valid[r_idx]   <= 1'b1;
                        tag_mem[r_idx] <= r_tag;
                        tgt_mem[r_idx] <= r_target;
                        ctr_mem[r_idx] <= WEAK_T;
                    end
                end else begin
                    // The fetch-time hit is trusted; whatever now occupies the slot is trained.
                    if (actual) begin
                        tgt_mem[r_idx] <= r_target;
                        if (ctr_mem[r_idx] != CTR_MAX) begin
                            ctr_mem[r_idx] <= ctr_mem[r_idx] + CTR_W'(1);
                        end
                    end else if (ctr_mem[r_idx] != '0) begin
                        ctr_mem[r_idx] <= ctr_mem[r_idx] - CTR_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Purpose : directed vector table plus hand-written reset / wrap sequences for the BTB.
// Latency : inputs driven on the falling edge, outputs sampled 1 time unit later.
// Backpressure: not applicable.
module tb_branch_target_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] f_pc;
    logic        f_hit;
    logic        f_taken;
    logic [31:0] f_target;
    logic [1:0]  r_branch;
    logic        r_equal;
    logic [31:0] r_pc;
    logic [31:0] r_target;
    logic        r_pred_hit;
    logic        r_pred_taken;
    logic        pipe_stall;
    logic        flush_btb;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [3:0]  branch_cnt;
    logic [3:0]  mispred_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    branch_target_predictor #(
        .ENTRIES(16),
        .ADDR_W (32),
        .CTR_W  (2),
        .CNT_W  (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .f_pc        (f_pc),
        .f_hit       (f_hit),
        .f_taken     (f_taken),
        .f_target    (f_target),
        .r_branch    (r_branch),
        .r_equal     (r_equal),
        .r_pc        (r_pc),
        .r_target    (r_target),
        .r_pred_hit  (r_pred_hit),
        .r_pred_taken(r_pred_taken),
        .pipe_stall  (pipe_stall),
        .flush_btb   (flush_btb),
        .mispredict  (mispredict),
        .redirect_pc (redirect_pc),
        .branch_cnt  (branch_cnt),
        .mispred_cnt (mispred_cnt)
    );

    typedef struct {
        logic [31:0] fpc;
        logic [1:0]  rb;
        logic        req;
        logic [31:0] rpc;
        logic [31:0] rtgt;
        logic        phit;
        logic        ptak;
        logic        stall;
        logic        flush;
        logic        hit;
        logic        tkn;
        logic [31:0] ftgt;
        logic        mp;
        logic [31:0] rdr;
        logic [3:0]  bcnt;
        logic [3:0]  mcnt;
    } vec_t;

    vec_t vecs [22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] fpc, input logic [1:0] rb, input logic req,
                         input logic [31:0] rpc, input logic [31:0] rtgt, input logic phit,
                         input logic ptak, input logic stall, input logic flush);
        f_pc         = fpc;
        r_branch     = rb;
        r_equal      = req;
        r_pc         = rpc;
        r_target     = rtgt;
        r_pred_hit   = phit;
        r_pred_taken = ptak;
        pipe_stall   = stall;
        flush_btb    = flush;
    endtask

    initial begin
        //        fpc    rb req rpc          rtgt    ph pt st fl | hit tk ftgt   mp rdr     b  m
        vecs[0]  = '{32'h40, 2'd0, 0, 32'h0,   32'h0,   0, 0, 0, 0,  0, 0, 32'h0,   0, 32'h4,   0, 0};
        vecs[1]  = '{32'h40, 2'd1, 1, 32'h40,  32'h80,  0, 0, 0, 0,  0, 0, 32'h0,   1, 32'h80,  0, 0};
        vecs[2]  = '{32'h40, 2'd0, 0, 32'h0,   32'h0,   0, 0, 0, 0,  1, 1, 32'h80,  0, 32'h4,   1, 1};
        vecs[3]  = '{32'h40, 2'd1, 1, 32'h40,  32'h80,  1, 1, 0, 0,  1, 1, 32'h80,  0, 32'h80,  1, 1};
        vecs[4]  = '{32'h40, 2'd1, 1, 32'h40,  32'h80,  1, 1, 0, 0,  1, 1, 32'h80,  0, 32'h80,  2, 1};
        vecs[5]  = '{32'h40, 2'd1, 1, 32'h40,  32'h80,  1, 1, 0, 0,  1, 1, 32'h80,  0, 32'h80,  3, 1};
        vecs[6]  = '{32'h40, 2'd1, 1, 32'h40,  32'h80,  1, 1, 0, 0,  1, 1, 32'h80,  0, 32'h80,  4, 1};
        vecs[7]  = '{32'h40, 2'd1, 0, 32'h40,  32'h80,  1, 1, 0, 0,  1, 1, 32'h80,  1, 32'h44,  5, 1};
        vecs[8]  = '{32'h40, 2'd0, 0, 32'h0,   32'h0,   0, 0, 0, 0,  1, 1, 32'h80,  0, 32'h4,   6, 2};
        vecs[9]  = '{32'h40, 2'd1, 0, 32'h40,  32'h80,  1, 1, 0, 0,  1, 1, 32'h80,  1, 32'h44,  6, 2};
        vecs[10] = '{32'h40, 2'd0, 0, 32'h0,   32'h0,   0, 0, 0, 0,  1, 0, 32'h80,  0, 32'h4,   7, 3};
        vecs[11] = '{32'h100,2'd3, 1, 32'h100, 32'h200, 0, 0, 0, 0,  0, 0, 32'h0,   0, 32'h104, 7, 3};
        vecs[12] = '{32'h100,2'd3, 0, 32'h100, 32'h200, 0, 0, 0, 0,  0, 0, 32'h0,   1, 32'h200, 8, 3};
        vecs[13] = '{32'h100,2'd0, 0, 32'h0,   32'h0,   0, 0, 0, 0,  1, 1, 32'h200, 0, 32'h4,   9, 4};
        vecs[14] = '{32'h40, 2'd0, 0, 32'h0,   32'h0,   0, 0, 0, 0,  0, 0, 32'h0,   0, 32'h4,   9, 4};
        vecs[15] = '{32'h140,2'd1, 1, 32'h140, 32'h300, 0, 0, 1, 0,  0, 0, 32'h0,   0, 32'h300, 9, 4};
        vecs[16] = '{32'h100,2'd0, 0, 32'h0,   32'h0,   0, 0, 0, 0,  1, 1, 32'h200, 0, 32'h4,   9, 4};
        vecs[17] = '{32'h100,2'd1, 1, 32'h84,  32'h400, 0, 0, 0, 1,  1, 1, 32'h200, 1, 32'h400, 9, 4};
        vecs[18] = '{32'h84, 2'd0, 0, 32'h0,   32'h0,   0, 0, 0, 0,  0, 0, 32'h0,   0, 32'h4,   10, 5};
        vecs[19] = '{32'h100,2'd0, 0, 32'h0,   32'h0,   0, 0, 0, 0,  0, 0, 32'h0,   0, 32'h4,   10, 5};
        vecs[20] = '{32'h0,  2'd0, 1, 32'h10,  32'h20,  0, 1, 0, 0,  0, 0, 32'h0,   0, 32'h20,  10, 5};
        vecs[21] = '{32'h0,  2'd1, 0, 32'hFFFFFFFC, 32'h8, 0, 1, 0, 0, 0, 0, 32'h0, 1, 32'h0,   10, 5};

        reset = 1'b1;
        drive(32'h0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            drive(vecs[i].fpc, vecs[i].rb, vecs[i].req, vecs[i].rpc, vecs[i].rtgt,
                  vecs[i].phit, vecs[i].ptak, vecs[i].stall, vecs[i].flush);
            #1;
            chk($sformatf("v%0d f_hit", i),       32'(f_hit),       32'(vecs[i].hit));
            chk($sformatf("v%0d f_taken", i),     32'(f_taken),     32'(vecs[i].tkn));
            chk($sformatf("v%0d f_target", i),    f_target,         vecs[i].ftgt);
            chk($sformatf("v%0d mispredict", i),  32'(mispredict),  32'(vecs[i].mp));
            chk($sformatf("v%0d redirect_pc", i), redirect_pc,      vecs[i].rdr);
            chk($sformatf("v%0d branch_cnt", i),  32'(branch_cnt),  32'(vecs[i].bcnt));
            chk($sformatf("v%0d mispred_cnt", i), 32'(mispred_cnt), 32'(vecs[i].mcnt));
        end

        // Five more correctly predicted not-taken resolves carry branch_cnt 11 -> 16 -> 0.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(32'h0, 2'd1, 1'b0, 32'h10, 32'h20, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        @(negedge clk);
        drive(32'h0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("wrap1 branch_cnt", 32'(branch_cnt), 32'd0);
        chk("wrap1 mispred_cnt", 32'(mispred_cnt), 32'd6);

        // Allocate 0x40, then reset in the middle of another allocate.
        @(negedge clk);
        drive(32'h40, 2'd1, 1'b1, 32'h40, 32'h80, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(32'h40, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("pre_rst f_hit", 32'(f_hit), 32'd1);
        chk("pre_rst branch_cnt", 32'(branch_cnt), 32'd1);
        chk("pre_rst mispred_cnt", 32'(mispred_cnt), 32'd7);

        @(negedge clk);
        reset = 1'b1;
        drive(32'h84, 2'd1, 1'b1, 32'h84, 32'h400, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("in_rst mispredict", 32'(mispredict), 32'd1);
        chk("in_rst redirect_pc", redirect_pc, 32'h400);

        @(negedge clk);
        reset = 1'b0;
        drive(32'h40, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("post_rst f_hit", 32'(f_hit), 32'd0);
        chk("post_rst f_taken", 32'(f_taken), 32'd0);
        chk("post_rst f_target", f_target, 32'h0);
        chk("post_rst branch_cnt", 32'(branch_cnt), 32'd0);
        chk("post_rst mispred_cnt", 32'(mispred_cnt), 32'd0);

        @(negedge clk);
        drive(32'h84, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("post_rst no_alloc f_hit", 32'(f_hit), 32'd0);

        // Sixteen resolve events from zero wrap a 4-bit counter back to zero.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(32'h0, 2'd1, 1'b0, 32'h10, 32'h20, 1'b0, 1'b0, 1'b0, 1'b0);
            #1;
            chk($sformatf("wrap2 step%0d branch_cnt", i), 32'(branch_cnt), 32'(i));
        end
        @(negedge clk);
        drive(32'h0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("wrap2 branch_cnt", 32'(branch_cnt), 32'd0);
        chk("wrap2 mispred_cnt", 32'(mispred_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
